// File: rtl/hw6_vga_tx.sv
// hw6_vga_tx: grayscale pixel stream to VGA timing transmitter.
// Pixels enter through a valid/ready FIFO. They are emitted as R=G=B during the active
// region of parameterised H/V counters. All outputs are registered (1-cycle latency).
// Optional feature macro: HW6_VGA_TX_PATTERN_EN adds a test_mode input that replaces the
// FIFO stream with a coordinate test pattern.
module hw6_vga_tx #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PREFILL    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef HW6_VGA_TX_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [7:0] pixel_in,
  input  logic       pixel_in_valid,
  output logic       pixel_in_ready,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HS,
  output logic       VS,
  output logic       frame_start,
  output logic       underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop, starve;

  logic [31:0]   h_ext, v_ext;
  logic          h_active, v_active, h_sync, v_sync, h_last, v_last;
  logic          run, active, first, pattern;
  logic [7:0]    r_d, g_d, b_d;
  logic          hs_d, vs_d, fs_d;

`ifdef HW6_VGA_TX_PATTERN_EN
  assign pattern = test_mode;
`else
  assign pattern = 1'b0;
`endif

  // Region decode on zero-extended counters so boundary sums never overflow the counter width
  assign h_ext    = 32'(h_cnt_q);
  assign v_ext    = 32'(v_cnt_q);
  assign h_active = h_ext < H_ACTIVE;
  assign v_active = v_ext < V_ACTIVE;
  assign h_sync   = (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
  assign v_sync   = (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);
  assign h_last   = h_ext == H_TOTAL - 1;
  assign v_last   = v_ext == V_TOTAL - 1;

  assign run    = state_q == StRun;
  assign active = run && h_active && v_active;
  assign first  = run && (h_cnt_q == '0) && (v_cnt_q == '0);

  assign full           = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty          = count_q == '0;
  assign pixel_in_ready = rst_n && !full;
  assign push           = pixel_in_valid && pixel_in_ready;
  // An empty FIFO is never bypassed: a same-cycle push does not rescue the pixel
  assign pop            = active && !pattern && !empty;
  assign starve         = active && !pattern && empty;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Next state: start on prefill, stop only at the last pixel of a frame
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    unique case (state_q)
      StIdle: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en && (pattern || count_q >= (AW+1)'(PREFILL))) state_d = StRun;
      end
      StRun: begin
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        if (h_last && v_last && !en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pixel_in;
  end

  // Next output values from the current counters
  always_comb begin
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    hs_d = 1'b1;
    vs_d = 1'b1;
    fs_d = 1'b0;
    if (run) begin
      hs_d = !h_sync;
      vs_d = !v_sync;
      fs_d = first;
      if (active) begin
        if (pattern) begin
          r_d = h_ext[7:0];
          g_d = v_ext[7:0];
          b_d = h_ext[7:0] ^ v_ext[7:0];
        end else if (!empty) begin
          r_d = mem_q[rd_ptr_q];
          g_d = mem_q[rd_ptr_q];
          b_d = mem_q[rd_ptr_q];
        end
      end
    end
  end

  // Output register; underflow set wins over the frame-start clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R           <= '0;
      G           <= '0;
      B           <= '0;
      HS          <= 1'b1;
      VS          <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      R           <= r_d;
      G           <= g_d;
      B           <= b_d;
      HS          <= hs_d;
      VS          <= vs_d;
      frame_start <= fs_d;
      if (starve)     underflow <= 1'b1;
      else if (first) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hw6_vga_tx.sv
// Directed bench for hw6_vga_tx with an 8x6 frame (4x3 active), FIFO_DEPTH=16, PREFILL=4.
module tb_hw6_vga_tx;

  logic       clk = 1'b0;
  logic       rst_n, en, pixel_in_valid, pixel_in_ready;
  logic [7:0] pixel_in, R, G, B;
  logic       HS, VS, frame_start, underflow;
  int         checks = 0;
  int         errors = 0;

  hw6_vga_tx #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FIFO_DEPTH(16), .PREFILL(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .pixel_in_ready(pixel_in_ready),
    .R(R), .G(G), .B(B), .HS(HS), .VS(VS),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pixel_in_valid = 1'b0; pixel_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({R, G, B} !== 24'd0) begin
      errors++; $display("FAIL reset_rgb got %0d/%0d/%0d exp 0/0/0", R, G, B);
    end
    checks++;
    if ({HS, VS} !== 2'b11) begin
      errors++; $display("FAIL reset_sync got HS=%b VS=%b exp 1/1", HS, VS);
    end
    checks++;
    if (pixel_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", pixel_in_ready);
    end
    checks++;
    if ({frame_start, underflow} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got fs=%b uf=%b exp 0/0", frame_start, underflow);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pixel_in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready got %b exp 1", pixel_in_ready);
    end
  endtask

  task automatic test_single_frame();
    int t, h, l;
    logic [7:0] ep;
    logic ehs, evs, efs;
    en = 1'b1;
    for (int i = 1; i <= 55; i++) begin
      pixel_in_valid = (i <= 12);
      pixel_in = 8'(i);
      @(posedge clk); #1;
      t = i - 6;
      if (t < 0) begin
        checks++;
        if (frame_start !== 1'b0) begin
          errors++; $display("FAIL sf_early_fs i=%0d got %b exp 0", i, frame_start);
        end
      end else begin
        h = t % 8; l = t / 8;
        if (t < 48) begin
          ep  = (l < 3 && h < 4) ? 8'(l * 4 + h + 1) : 8'd0;
          ehs = !(h == 5 || h == 6);
          evs = (l != 4);
          efs = (t == 0);
        end else begin
          ep = 8'd0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
        end
        checks++;
        if ({R, G, B} !== {ep, ep, ep}) begin
          errors++; $display("FAIL sf_rgb t=%0d got %0d/%0d/%0d exp %0d", t, R, G, B, ep);
        end
        checks++;
        if ({HS, VS} !== {ehs, evs}) begin
          errors++; $display("FAIL sf_sync t=%0d got %b%b exp %b%b", t, HS, VS, ehs, evs);
        end
        checks++;
        if (frame_start !== efs) begin
          errors++; $display("FAIL sf_fs t=%0d got %b exp %b", t, frame_start, efs);
        end
        checks++;
        if (underflow !== 1'b0) begin
          errors++; $display("FAIL sf_uf t=%0d got %b exp 0", t, underflow);
        end
        if (t == 0) en = 1'b0;
      end
    end
    pixel_in_valid = 1'b0;
  endtask

  task automatic test_underflow();
    int t, c, h, l, slot;
    logic [7:0] ep;
    logic efs, euf;
    en = 1'b1;
    for (int i = 1; i <= 103; i++) begin
      pixel_in_valid = (i <= 6) || (i == 36);
      pixel_in = (i <= 6) ? 8'(i) : 8'd7;
      @(posedge clk); #1;
      t = i - 6;
      if (t >= 0) begin
        c = t % 48; h = c % 8; l = c / 8; slot = l * 4 + h;
        if (t < 48) begin
          ep  = (l < 3 && h < 4 && slot < 6) ? 8'(slot + 1) : 8'd0;
          efs = (c == 0);
          euf = (t >= 10);
        end else if (t < 96) begin
          ep  = (c == 0) ? 8'd7 : 8'd0;
          efs = (c == 0);
          euf = (c != 0);
        end else begin
          ep = 8'd0; efs = 1'b0; euf = 1'b1;
        end
        checks++;
        if (R !== ep) begin
          errors++; $display("FAIL uf_r t=%0d got %0d exp %0d", t, R, ep);
        end
        checks++;
        if (frame_start !== efs) begin
          errors++; $display("FAIL uf_fs t=%0d got %b exp %b", t, frame_start, efs);
        end
        checks++;
        if (underflow !== euf) begin
          errors++; $display("FAIL uf_flag t=%0d got %b exp %b", t, underflow, euf);
        end
        if (t == 48) en = 1'b0;
      end
    end
    pixel_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int t, f, c, h, l, slot;
    logic [7:0] ep;
    logic efs, euf;
    en = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      pixel_in_valid = 1'b1;
      pixel_in = (i <= 16) ? 8'(i) : 8'hEE;
      @(posedge clk); #1;
      checks++;
      if (pixel_in_ready !== (i < 16)) begin
        errors++; $display("FAIL bp_ready i=%0d got %b exp %b", i, pixel_in_ready, (i < 16));
      end
    end
    pixel_in_valid = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      @(posedge clk); #1;
      t = i - 2;
      if (t < 0) begin
        checks++;
        if (frame_start !== 1'b0) begin
          errors++; $display("FAIL bp_early_fs got %b exp 0", frame_start);
        end
      end else begin
        f = t / 48; c = t % 48; h = c % 8; l = c / 8; slot = f * 12 + l * 4 + h;
        if (t < 96) begin
          ep  = (l < 3 && h < 4 && slot < 16) ? 8'(slot + 1) : 8'd0;
          efs = (c == 0);
          euf = (t >= 56);
        end else begin
          ep = 8'd0; efs = 1'b0; euf = 1'b1;
        end
        checks++;
        if (R !== ep) begin
          errors++; $display("FAIL bp_r t=%0d got %0d exp %0d", t, R, ep);
        end
        checks++;
        if (frame_start !== efs) begin
          errors++; $display("FAIL bp_fs t=%0d got %b exp %b", t, frame_start, efs);
        end
        checks++;
        if (underflow !== euf) begin
          errors++; $display("FAIL bp_uf t=%0d got %b exp %b", t, underflow, euf);
        end
        if (t == 0) begin
          checks++;
          if (pixel_in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_after_pop got %b exp 1", pixel_in_ready);
          end
        end
        if (t == 48) en = 1'b0;
      end
    end
  endtask

  task automatic test_en_drop();
    int t, h, l, slot;
    logic [7:0] ep;
    logic ehs, evs, efs, euf;
    en = 1'b1;
    for (int i = 1; i <= 58; i++) begin
      pixel_in_valid = (i <= 8);
      pixel_in = 8'(i);
      @(posedge clk); #1;
      t = i - 6;
      if (t >= 0) begin
        h = t % 8; l = t / 8; slot = l * 4 + h;
        if (t < 48) begin
          ep  = (l < 3 && h < 4 && slot < 8) ? 8'(slot + 1) : 8'd0;
          ehs = !(h == 5 || h == 6);
          evs = (l != 4);
          efs = (t == 0);
          euf = (t >= 16);
        end else begin
          ep = 8'd0; ehs = 1'b1; evs = 1'b1; efs = 1'b0; euf = 1'b1;
        end
        checks++;
        if (R !== ep) begin
          errors++; $display("FAIL ed_r t=%0d got %0d exp %0d", t, R, ep);
        end
        checks++;
        if ({HS, VS} !== {ehs, evs}) begin
          errors++; $display("FAIL ed_sync t=%0d got %b%b exp %b%b", t, HS, VS, ehs, evs);
        end
        checks++;
        if ({frame_start, underflow} !== {efs, euf}) begin
          errors++;
          $display("FAIL ed_flags t=%0d got fs=%b uf=%b exp %b/%b", t, frame_start, underflow,
                   efs, euf);
        end
        if (t == 8) en = 1'b0;
      end
    end
    // Refill while idle, then re-enable; stops just before h=2,v=1 reaches the output
    for (int i = 1; i <= 19; i++) begin
      pixel_in_valid = (i <= 8);
      pixel_in = 8'(100 + i);
      en = (i >= 9);
      @(posedge clk); #1;
      t = i - 10;
      if (t < 0) begin
        checks++;
        if (frame_start !== 1'b0) begin
          errors++; $display("FAIL ed_restart_early i=%0d got %b exp 0", i, frame_start);
        end
      end else begin
        h = t % 8; l = t / 8;
        ep = (h < 4) ? 8'(101 + l * 4 + h) : 8'd0;
        checks++;
        if (R !== ep) begin
          errors++; $display("FAIL ed_restart_r t=%0d got %0d exp %0d", t, R, ep);
        end
        checks++;
        if ({frame_start, underflow} !== {(t == 0), 1'b0}) begin
          errors++;
          $display("FAIL ed_restart_flags t=%0d got fs=%b uf=%b exp %b/0", t, frame_start,
                   underflow, (t == 0));
        end
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] ep;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({R, G, B} !== 24'd0 || {HS, VS} !== 2'b11) begin
      errors++; $display("FAIL mfr_out got %0d/%0d/%0d HS=%b VS=%b exp 0/0/0 1 1", R, G, B, HS, VS);
    end
    checks++;
    if ({frame_start, underflow, pixel_in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mfr_flags got fs=%b uf=%b rdy=%b exp 0/0/0", frame_start, underflow,
               pixel_in_ready);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      pixel_in_valid = (i <= 3) || (i == 9);
      pixel_in = 8'(200 + ((i == 9) ? 4 : i));
      @(posedge clk); #1;
      ep = (i == 11) ? 8'd201 : 8'd0;
      checks++;
      if (frame_start !== (i == 11)) begin
        errors++; $display("FAIL mfr_fs i=%0d got %b exp %b", i, frame_start, (i == 11));
      end
      checks++;
      if (R !== ep) begin
        errors++; $display("FAIL mfr_r i=%0d got %0d exp %0d", i, R, ep);
      end
      if (i == 1) begin
        checks++;
        if (pixel_in_ready !== 1'b1) begin
          errors++; $display("FAIL mfr_ready got %b exp 1", pixel_in_ready);
        end
      end
    end
    pixel_in_valid = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underflow();
    test_backpressure();
    test_en_drop();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
